// File: rtl/div_request_arbiter.sv
// Round-robin arbiter sharing one start/done divider among NREQ requesters.
// Divide-by-zero is answered locally; a hung divider is cut off after TIMEOUT cycles.
module div_request_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64,
    parameter int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_dividend,
    input  logic [NREQ*WIDTH-1:0] req_divisor,
    output logic [NREQ-1:0]       ack,
    output logic                  div_start,
    output logic [WIDTH-1:0]      div_dividend,
    output logic [WIDTH-1:0]      div_divisor,
    input  logic                  div_done,
    input  logic [WIDTH-1:0]      div_quotient,
    input  logic [WIDTH:0]        div_remainder,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [WIDTH-1:0]      resp_quotient,
    output logic [WIDTH:0]        resp_remainder,
    output logic                  resp_dbz,
    output logic                  resp_timeout,
    output logic                  busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam int              CNTW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int              IDW1     = IDW + 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);
    localparam logic [IDW-1:0]  ID_LAST  = IDW'(NREQ - 1);
    localparam logic [IDW:0]    NREQ_W   = IDW1'(NREQ);

    state_t            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              done_q, done_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              start_q, start_d;
    logic [WIDTH-1:0]  dividend_q, dividend_d;
    logic [WIDTH-1:0]  divisor_q, divisor_d;
    logic              resp_valid_q, resp_valid_d;
    logic [IDW-1:0]    resp_id_q, resp_id_d;
    logic [WIDTH-1:0]  resp_quot_q, resp_quot_d;
    logic [WIDTH:0]    resp_rem_q, resp_rem_d;
    logic              resp_dbz_q, resp_dbz_d;
    logic              resp_tmo_q, resp_tmo_d;

    logic [NREQ-1:0]   req_rot;
    logic [IDW:0]      gnt_off;
    logic [IDW:0]      gnt_sum;
    logic [IDW-1:0]    gnt_idx;
    logic              gnt_any;
    logic [WIDTH-1:0]  sel_dividend;
    logic [WIDTH-1:0]  sel_divisor;

    // Rotate requests so the pointer sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        req_rot = NREQ'({req, req} >> ptr_q);
        gnt_any = |req_rot;
        gnt_off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) gnt_off = IDW1'(k);
        end
        gnt_sum = {1'b0, ptr_q} + gnt_off;
        if (gnt_sum >= NREQ_W) gnt_sum = gnt_sum - NREQ_W;
        gnt_idx = gnt_sum[IDW-1:0];
        sel_dividend = '0;
        sel_divisor  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_idx == IDW'(k)) begin
                sel_dividend = req_dividend[k*WIDTH +: WIDTH];
                sel_divisor  = req_divisor[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        done_d       = div_done;
        ack_d        = '0;
        start_d      = 1'b0;
        dividend_d   = dividend_q;
        divisor_d    = divisor_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_quot_d  = resp_quot_q;
        resp_rem_d   = resp_rem_q;
        resp_dbz_d   = resp_dbz_q;
        resp_tmo_d   = resp_tmo_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_any) begin
                    ack_d      = NREQ'(1) << gnt_idx;
                    dividend_d = sel_dividend;
                    divisor_d  = sel_divisor;
                    resp_id_d  = gnt_idx;
                    ptr_d      = (gnt_idx == ID_LAST) ? '0 : gnt_idx + 1'b1;
                    if (sel_divisor == '0) begin
                        resp_valid_d = 1'b1;
                        resp_quot_d  = '1;
                        resp_rem_d   = {1'b0, sel_dividend};
                        resp_dbz_d   = 1'b1;
                        resp_tmo_d   = 1'b0;
                        state_d      = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                start_d = 1'b1;
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Edge detect: a done level still high from the previous job is ignored.
                if (div_done && !done_q) begin
                    resp_valid_d = 1'b1;
                    resp_quot_d  = div_quotient;
                    resp_rem_d   = div_remainder;
                    state_d      = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    resp_valid_d = 1'b1;
                    resp_quot_d  = '0;
                    resp_rem_d   = '0;
                    resp_tmo_d   = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_dbz_d   = 1'b0;
                    resp_tmo_d   = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            done_q       <= 1'b0;
            ack_q        <= '0;
            start_q      <= 1'b0;
            dividend_q   <= '0;
            divisor_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_quot_q  <= '0;
            resp_rem_q   <= '0;
            resp_dbz_q   <= 1'b0;
            resp_tmo_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            ack_q        <= ack_d;
            start_q      <= start_d;
            dividend_q   <= dividend_d;
            divisor_q    <= divisor_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_quot_q  <= resp_quot_d;
            resp_rem_q   <= resp_rem_d;
            resp_dbz_q   <= resp_dbz_d;
            resp_tmo_q   <= resp_tmo_d;
        end
    end

    assign ack            = ack_q;
    assign div_start      = start_q;
    assign div_dividend   = dividend_q;
    assign div_divisor    = divisor_q;
    assign resp_valid     = resp_valid_q;
    assign resp_id        = resp_id_q;
    assign resp_quotient  = resp_quot_q;
    assign resp_remainder = resp_rem_q;
    assign resp_dbz       = resp_dbz_q;
    assign resp_timeout   = resp_tmo_q;
    assign busy           = (state_q != S_IDLE);

endmodule
